// File: rtl/const_lut_arbiter.sv
// const_lut_arbiter
// -----------------
// Shares one combinational constant lookup table between two requesters.
// Arbitration is round-robin. Each requester has a valid/ready request
// channel and a valid/ready response channel. The response is registered
// and holds under backpressure. This block is the only driver of the
// shared LUT index.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   req0_valid/index/ready  requester 0 request channel
//   req1_valid/index/ready  requester 1 request channel
//   rsp0_valid/data/ready   requester 0 response channel
//   rsp1_valid/data/ready   requester 1 response channel
//   lut_index               index driven to the shared LUT
//   lut_value               LUT output, combinational from lut_index
//   busy                    a response is currently held
module const_lut_arbiter #(
    parameter int IDX_W  = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [IDX_W-1:0]  req0_index,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [IDX_W-1:0]  req1_index,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    input  logic              rsp1_ready,
    output logic [IDX_W-1:0]  lut_index,
    input  logic [DATA_W-1:0] lut_value,
    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q;
    logic               last_grant_q;
    logic               rsp0_valid_q;
    logic               rsp1_valid_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic [IDX_W-1:0]   idx_hold_q;

    logic               owner_valid;
    logic               owner_ready;
    logic               handshake;
    logic               can_accept;
    logic               grant_valid;
    logic               grant_id;

    // The owner's handshake frees the response register in the same cycle,
    // so a new grant can land without a bubble. The non-owner's rsp_ready
    // never participates.
    always_comb begin
        owner_valid = owner_q ? rsp1_valid_q : rsp0_valid_q;
        owner_ready = owner_q ? rsp1_ready   : rsp0_ready;
        handshake   = (state_q == RESP) && owner_valid && owner_ready;
        can_accept  = !reset && ((state_q == IDLE) || handshake);
    end

    // Round-robin: on a tie the requester not granted last time wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (can_accept) begin
            if (req0_valid && req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant_q;
            end else if (req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    // Without a grant the LUT index holds its last value so the table
    // input does not toggle while idle.
    always_comb begin
        if (reset) begin
            lut_index = '0;
        end else if (grant_valid) begin
            lut_index = grant_id ? req1_index : req0_index;
        end else begin
            lut_index = idx_hold_q;
        end
    end

    always_comb begin
        state_d = state_q;
        if (grant_valid) begin
            state_d = RESP;
        end else if (handshake) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Response datapath and arbitration pointer. A handshake with no new
    // grant only clears valid; the stale data is left in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_data_q   <= '0;
            idx_hold_q   <= '0;
        end else if (grant_valid) begin
            owner_q      <= grant_id;
            last_grant_q <= grant_id;
            rsp0_valid_q <= ~grant_id;
            rsp1_valid_q <= grant_id;
            rsp_data_q   <= lut_value;
            idx_hold_q   <= lut_index;
        end else if (handshake) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end
    end

    assign req0_ready = grant_valid && !grant_id;
    assign req1_ready = grant_valid && grant_id;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = rsp_data_q;
    assign rsp1_data  = rsp_data_q;
    assign busy       = (state_q == RESP);

endmodule
